// File: rtl/bch_serial_encoder.sv
// Bit-serial systematic BCH encoder: message bits pass through, then the
// remainder of m(x)*x^PAR mod g(x). Define BCH_ENC_PARITY_ONLY_EN to emit parity only.
module bch_serial_encoder #(
  parameter int                 PARAM_K   = 16,
  parameter int                 PARAM_PAR = 15,
  parameter logic [PARAM_PAR:0] PARAM_G   = 16'h8FAF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic busy,
  output logic done
);

  localparam int MAX_LEN = (PARAM_K > PARAM_PAR) ? PARAM_K : PARAM_PAR;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0]        K_LAST = CW'(PARAM_K - 1);
  localparam logic [CW-1:0]        P_LAST = CW'(PARAM_PAR - 1);
  localparam logic [PARAM_PAR-1:0] G_LOW  = PARAM_G[PARAM_PAR-1:0];

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_PAR} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [PARAM_PAR-1:0] r, r_nxt;
  logic                 done_nxt;
  logic                 msg_xfer;
  logic                 fb;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      r     <= r_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state != S_IDLE);
  assign fb   = in_bit ^ r[PARAM_PAR-1];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    r_nxt     = r;
    done_nxt  = 1'b0;
    msg_xfer  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          r_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = S_MSG;
        end
      end

      S_MSG: begin
`ifdef BCH_ENC_PARITY_ONLY_EN
        in_ready = 1'b1;
        msg_xfer = in_valid;
`else
        out_bit   = in_bit;
        out_valid = in_valid;
        in_ready  = out_ready;
        msg_xfer  = in_valid & out_ready;
`endif
        if (msg_xfer) begin
          // Galois LFSR division step: feedback folds in g(x) minus its leading term.
          r_nxt = {r[PARAM_PAR-2:0], 1'b0} ^ (fb ? G_LOW : '0);
          if (cnt == K_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_PAR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      S_PAR: begin
        out_valid = 1'b1;
        out_bit   = r[PARAM_PAR-1];
        out_last  = (cnt == P_LAST);
        if (out_ready) begin
          r_nxt   = {r[PARAM_PAR-2:0], 1'b0};
          cnt_nxt = cnt + 1'b1;
          if (out_last) begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Self-checking bench for bch_serial_encoder: polynomial long-division model,
// expected-bit queue and a per-cycle compare process.
module tb_bch_serial_encoder;

  localparam int           K   = 16;
  localparam int           PAR = 15;
  localparam int           N   = K + PAR;
  localparam logic [PAR:0] G   = 16'h8FAF;
`ifdef BCH_ENC_PARITY_ONLY_EN
  localparam bit PONLY = 1'b1;
`else
  localparam bit PONLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, in_bit, in_valid, out_ready;
  logic in_ready, out_bit, out_valid, out_last, busy, done;

  int checks = 0;
  int errors = 0;

  bch_serial_encoder #(.PARAM_K(K), .PARAM_PAR(PAR), .PARAM_G(G)) dut (
    .clk(clk), .rst(rst), .start(start), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Remainder of c(x) mod g(x) by schoolbook long division over GF(2).
  function automatic logic [PAR-1:0] mod_g(input logic [N-1:0] c);
    logic [N-1:0] gw;
    gw = N'(G);
    for (int i = N - 1; i >= PAR; i--)
      if (c[i]) c = c ^ (gw << (i - PAR));
    return c[PAR-1:0];
  endfunction

  function automatic logic [PAR-1:0] parity(input logic [K-1:0] m);
    return mod_g({m, {PAR{1'b0}}});
  endfunction

  // Shared between driver and compare process.
  bit           exp_q[$];
  logic [N-1:0] got_bits;
  int           got_n;
  int           phase;       // 0 idle, 1 message, 2 parity
  bit           mon_en;
  bit           done_exp, prev_stall, prev_bit;

  always @(negedge clk) begin
    if (!mon_en) begin
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("done", done, done_exp);
      done_exp = 1'b0;
      case (phase)
        0: begin
          check("idle_out_valid", out_valid, 0);
          check("idle_in_ready", in_ready, 0);
          check("idle_busy", busy, 0);
        end
        1: begin
          check("msg_busy", busy, 1);
          if (PONLY) begin
            check("msg_in_ready", in_ready, 1);
            check("msg_out_valid", out_valid, 0);
          end else begin
            check("msg_in_ready", in_ready, out_ready);
            check("msg_out_valid", out_valid, in_valid);
          end
        end
        default: begin
          check("par_busy", busy, 1);
          check("par_out_valid", out_valid, 1);
          check("par_in_ready", in_ready, 0);
        end
      endcase
      if (prev_stall) check("stall_hold", out_bit, prev_bit);
      if (out_valid) check("out_last", out_last, (phase == 2) && (exp_q.size() == 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("out_bit", out_bit, exp_q.pop_front());
          got_bits = {got_bits[N-2:0], out_bit};
          got_n++;
          if (exp_q.size() == 0) done_exp = 1'b1;
        end
      end
      prev_stall = (phase == 2) && out_valid && !out_ready;
      prev_bit   = out_bit;
    end
  end

  task automatic encode(input logic [K-1:0] msg, input bit stall, output logic [PAR-1:0] par_got);
    logic [PAR-1:0] expp;
    int i, cnt, budget;
    expp = parity(msg);
    if (!PONLY) for (int b = K - 1; b >= 0; b--) exp_q.push_back(msg[b]);
    for (int b = PAR - 1; b >= 0; b--) exp_q.push_back(expp[b]);
    got_bits = '0;
    got_n    = 0;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; phase = 1;
    i = K - 1; budget = 2000;
    while (i >= 0 && budget > 0) begin
      in_bit    = msg[i];
      in_valid  = stall ? ($urandom_range(3) != 0) : 1'b1;
      out_ready = stall ? ($urandom_range(3) != 0) : 1'b1;
      start     = stall ? ($urandom_range(7) == 0) : 1'b0;
      @(posedge clk);
      if (in_valid && (PONLY || out_ready)) i--;
      budget--;
      #1;
    end
    if (budget == 0) check("msg_timeout", 1, 0);
    phase = 2; cnt = 0; budget = 2000;
    while (cnt < PAR && budget > 0) begin
      out_ready = stall ? ($urandom_range(2) != 0) : 1'b1;
      in_valid  = $urandom_range(1);
      in_bit    = $urandom_range(1);
      start     = stall ? ($urandom_range(7) == 0) : 1'b0;
      @(posedge clk);
      if (out_ready) cnt++;
      budget--;
      #1;
    end
    if (budget == 0) check("par_timeout", 1, 0);
    phase = 0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    check("nbits", got_n, PONLY ? PAR : N);
    if (PONLY) begin
      check("parity", got_bits[PAR-1:0], expp);
      check("syndrome", mod_g({msg, got_bits[PAR-1:0]}), 0);
    end else begin
      check("codeword", got_bits, {msg, expp});
      check("syndrome", mod_g(got_bits), 0);
    end
    par_got = got_bits[PAR-1:0];
    exp_q.delete();
  endtask

  initial begin
    logic [PAR-1:0] p, pa, pb, pc;
    logic [K-1:0]   m;
    rst = 1'b1; start = 1'b0; in_bit = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    phase = 0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; mon_en = 1'b1;

    // Hand-derived pins for the model: x^15 mod g = g - x^15.
    check("model_0001", parity(16'h0001), 15'h0FAF);
    check("model_zero", parity(16'h0000), 15'h0000);
    check("model_8000", parity(16'h8000), mod_g({16'h0000, 15'h0FAF} << 15));

    encode(16'h0000, 1'b0, p);
    check("zero_parity", p, 15'h0000);
    encode(16'h0001, 1'b0, p);
    check("one_parity", p, 15'h0FAF);

    encode(16'hA5C3, 1'b1, pa);
    encode(16'h1234, 1'b1, pb);
    encode(16'hA5C3 ^ 16'h1234, 1'b1, pc);
    check("linearity", pa ^ pb, pc);

    // Abandon a codeword after 7 message bits; start during MSG must be ignored.
    mon_en = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_out_valid", out_valid, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_bit", out_bit, 0);
    check("abort_out_last", out_last, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; phase = 0; mon_en = 1'b1;
    encode(16'h0001, 1'b0, p);
    check("after_abort_parity", p, 15'h0FAF);

    for (int n = 0; n < 200; n++) begin
      m = K'($urandom);
      encode(m, 1'b1, p);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
